cs_frame_controller: RTL and testbench
======================================

CS_FRAME_CONTROLLER -- requirements
Module: cs_frame_controller

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- M, 64: measurements per frame.
- N, 256: reconstructed signal length.
- BPW, 1 (1..4): bytes per stored word.
- SIGN_EXT, 0: 1 sign-extends stored words to 32 bits, 0 zero-extends.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- rx_valid, in, 1: one-cycle pulse, byte received.
- rx_byte, in, 8: received byte.
- frame_abort, in, 1: synchronous pulse, discard the current frame.
- tx_req, in, 1: one-cycle pulse, sender consumed tx_byte.
- tx_byte, out, 8: current output byte.
- tx_valid, out, 1: tx_byte holds a result byte.
- ap_start, out, 1: solver start.
- ap_ready, in, 1: solver accepted start.
- ap_done, in, 1: solver finished (pulse).
- phi_address, in, clog2(M*N); phi_ce, in, 1; phi_q, out, 32: matrix read port.
- y_address, in, clog2(M); y_ce, in, 1; y_q, out, 32: measurement read port.
- x_address, in, clog2(N); x_ce, in, 1; x_we, in, 1; x_d, in, 32: result write port.
- busy, out, 1: state is not LOAD_Y.
- state, out, 3: current state code.
- overflow_err, out, 1: sticky, byte arrived outside a load state.

Function
REQ-003 The block SHALL have states LOAD_Y=0, LOAD_PHI=1, START=2, SOLVE=3, SEND=4.
REQ-004 In LOAD_Y, each rx_valid SHALL store rx_byte into y word (count/BPW), byte lane (count%BPW), little-endian; after M*BPW bytes the block SHALL go to LOAD_PHI on the next clk.
REQ-005 LOAD_PHI SHALL work the same way for M*N*BPW bytes into phi, row-major (address = row*N+col), then go to START.
REQ-006 In START, ap_start SHALL be 1 and held until ap_ready is sampled 1; the block SHALL then drop ap_start and go to SOLVE in the same edge.
REQ-007 If ap_done and ap_ready are both 1 in START, the block SHALL go directly to SEND.
REQ-008 In SOLVE, the block SHALL go to SEND on ap_done=1.
REQ-009 phi_q and y_q SHALL be registered with 1-cycle latency: updated on clk when ce=1, held when ce=0, valid in every state.
REQ-010 Each stored word SHALL be extended to 32 bits per SIGN_EXT.
REQ-011 When x_ce&x_we=1 in START or SOLVE, result[x_address] SHALL be written with x_d[8*BPW-1:0]; writes in any other state SHALL be ignored.
REQ-012 In SEND:
- tx_valid SHALL be 1.
- tx_byte SHALL be combinationally result byte (idx%BPW) of word (idx/BPW).
- idx starts at 0 on SEND entry; each tx_req increments idx.
- tx_req on the last byte (idx=N*BPW-1) SHALL set tx_valid=0 and return to LOAD_Y with all counters cleared.
REQ-013 tx_req outside SEND SHALL be ignored; tx_byte SHALL be 0 when tx_valid=0.
REQ-014 rx_valid in START, SOLVE or SEND SHALL discard the byte and set overflow_err=1; only rst clears overflow_err.
REQ-015 frame_abort in LOAD_Y, LOAD_PHI or SEND SHALL clear all counters and go to LOAD_Y on the next clk; in START or SOLVE it SHALL be ignored.
REQ-016 frame_abort SHALL win over a simultaneous rx_valid or tx_req; that byte is discarded and no error is flagged.
REQ-017 Memory contents SHALL persist across frames and aborts; a new frame overwrites them.

Reset
REQ-018 On rst=1, the block SHALL asynchronously enter LOAD_Y with all counters 0.
REQ-019 On rst=1, all outputs SHALL be 0: tx_byte, tx_valid, ap_start, busy, state, overflow_err, phi_q and y_q.
REQ-020 Memories SHALL NOT be cleared by reset.
REQ-021 Reset asserted mid-frame or mid-solve SHALL abandon the frame; the bench SHALL reset the solver alongside this block.

Verification (M=2, N=4, BPW=2 unless noted)
REQ-022 Frame load: send y bytes 01 02 03 04, then 16 phi bytes 10..1F.
- Required: y_q(addr1)=0x0403 one cycle after y_ce.
- Required: phi_q(addr7)=0x1F1E.
- Required: state=2, ap_start=1.
REQ-023 Start handshake:
- Hold ap_ready=0 for 5 cycles -> ap_start stays 1 throughout.
- Then ap_ready=1 -> ap_start=0 and state=3 on the next cycle.
REQ-024 Readout:
- Solver writes x_d=0x0000ABCD at x_address 0..3, then pulses ap_done.
- Required: tx_valid=1, tx_byte sequence CD AB CD AB CD AB CD AB over 8 tx_req.
- Required: then tx_valid=0 and state=0.
REQ-025 SIGN_EXT=1, BPW=1, y byte 0x80 -> y_q=0xFFFFFF80; with SIGN_EXT=0 -> y_q=0x00000080.
REQ-026 Abort and overflow:
- frame_abort after 3 phi bytes -> state=0; a fresh full frame loads correctly.
- rx_valid during SOLVE -> overflow_err=1 and stays 1 until rst.
REQ-027 Reset during SEND at idx=3 -> all outputs 0 immediately; the next frame reads out from idx 0.

Source files
------------

// File: rtl/cs_frame_controller.sv
// Compressed-sensing frame controller: loads y/phi from a byte stream, starts the solver,
// and streams the reconstructed result back out byte by byte.
module cs_frame_controller #(
  parameter int M        = 64,
  parameter int N        = 256,
  parameter int BPW      = 1,
  parameter int SIGN_EXT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic                      frame_abort,
  input  logic                      tx_req,
  output logic [7:0]                tx_byte,
  output logic                      tx_valid,
  output logic                      ap_start,
  input  logic                      ap_ready,
  input  logic                      ap_done,
  input  logic [$clog2(M*N)-1:0]    phi_address,
  input  logic                      phi_ce,
  output logic [31:0]               phi_q,
  input  logic [$clog2(M)-1:0]      y_address,
  input  logic                      y_ce,
  output logic [31:0]               y_q,
  input  logic [$clog2(N)-1:0]      x_address,
  input  logic                      x_ce,
  input  logic                      x_we,
  input  logic [31:0]               x_d,
  output logic                      busy,
  output logic [2:0]                state,
  output logic                      overflow_err
);

  localparam int PAW = $clog2(M*N);
  localparam int YAW = $clog2(M);
  localparam int XAW = $clog2(N);
  localparam int WW  = 8*BPW;
  localparam int CW  = $clog2(M*N+1);

  typedef enum logic [2:0] {
    LOAD_Y   = 3'd0,
    LOAD_PHI = 3'd1,
    START    = 3'd2,
    SOLVE    = 3'd3,
    SEND     = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   word_q;
  logic [1:0]      lane_q;
  logic            overflow_q;

  logic            lane_last, y_last, phi_last, x_last;
  logic            y_wr, phi_wr, x_wr;
  logic [WW-1:0]   y_rd, phi_rd;
  logic [7:0]      x_lane [BPW];
  logic [7:0]      tx_sel;

  assign lane_last = lane_q == 2'(BPW-1);
  assign y_last    = word_q == CW'(M-1);
  assign phi_last  = word_q == CW'(M*N-1);
  assign x_last    = word_q == CW'(N-1);

  assign y_wr   = (state_q == LOAD_Y)   && rx_valid && !frame_abort;
  assign phi_wr = (state_q == LOAD_PHI) && rx_valid && !frame_abort;
  assign x_wr   = x_ce && x_we && ((state_q == START) || (state_q == SOLVE));

  // One byte-wide memory per lane so a received byte writes only its own lane.
  for (genvar b = 0; b < BPW; b++) begin : g_lane
    logic [7:0] y_m   [M];
    logic [7:0] phi_m [M*N];
    logic [7:0] x_m   [N];

    always_ff @(posedge clk) begin
      if (y_wr && lane_q == 2'(b))   y_m[word_q[YAW-1:0]]   <= rx_byte;
      if (phi_wr && lane_q == 2'(b)) phi_m[word_q[PAW-1:0]] <= rx_byte;
      if (x_wr)                      x_m[x_address]         <= x_d[8*b +: 8];
    end

    assign y_rd[8*b +: 8]   = y_m[y_address];
    assign phi_rd[8*b +: 8] = phi_m[phi_address];
    assign x_lane[b]        = x_m[word_q[XAW-1:0]];
  end

  if (WW < 32) begin : g_unused
    logic unused_xd;
    assign unused_xd = ^x_d[31:WW];
  end

  function automatic logic [31:0] extend(input logic [WW-1:0] w);
    logic [31:0] r;
    r         = (SIGN_EXT != 0 && w[WW-1]) ? '1 : '0;
    r[WW-1:0] = w;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      phi_q <= '0;
    end else begin
      if (y_ce)   y_q   <= extend(y_rd);
      if (phi_ce) phi_q <= extend(phi_rd);
    end
  end

  // word_q/lane_q double as the load write pointer and the readout index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_Y;
      word_q     <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rx_valid && !frame_abort &&
          (state_q == START || state_q == SOLVE || state_q == SEND))
        overflow_q <= 1'b1;
      case (state_q)
        LOAD_Y, LOAD_PHI: begin
          if (frame_abort) begin
            word_q  <= '0;
            lane_q  <= '0;
            state_q <= LOAD_Y;
          end else if (rx_valid) begin
            if (!lane_last) begin
              lane_q <= lane_q + 2'd1;
            end else begin
              lane_q <= '0;
              if (state_q == LOAD_Y && y_last) begin
                word_q  <= '0;
                state_q <= LOAD_PHI;
              end else if (state_q == LOAD_PHI && phi_last) begin
                word_q  <= '0;
                state_q <= START;
              end else begin
                word_q <= word_q + CW'(1);
              end
            end
          end
        end
        START: begin
          if (ap_ready) begin
            if (ap_done) state_q <= SEND;
            else         state_q <= SOLVE;
          end
        end
        SOLVE: begin
          if (ap_done) state_q <= SEND;
        end
        SEND: begin
          if (frame_abort) begin
            word_q  <= '0;
            lane_q  <= '0;
            state_q <= LOAD_Y;
          end else if (tx_req) begin
            if (!lane_last) begin
              lane_q <= lane_q + 2'd1;
            end else begin
              lane_q <= '0;
              if (x_last) begin
                word_q  <= '0;
                state_q <= LOAD_Y;
              end else begin
                word_q <= word_q + CW'(1);
              end
            end
          end
        end
        default: state_q <= LOAD_Y;
      endcase
    end
  end

  always_comb begin
    tx_sel = 8'h00;
    for (int b = 0; b < BPW; b++)
      if (lane_q == 2'(b)) tx_sel = x_lane[b];
  end

  assign state        = state_q;
  assign busy         = state_q != LOAD_Y;
  assign ap_start     = state_q == START;
  assign tx_valid     = state_q == SEND;
  assign tx_byte      = tx_valid ? tx_sel : 8'h00;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cs_frame_controller.sv
// Self-checking bench for cs_frame_controller: table-driven handshake/readout plus
// hand-written sequences for sign extension, abort, overflow and mid-readout reset.
module tb_cs_frame_controller;

  localparam int M   = 2;
  localparam int N   = 4;
  localparam int BPW = 2;

  logic        clk;
  logic        rst;
  logic        rx_valid, rxValidSe;
  logic [7:0]  rx_byte;
  logic        frame_abort, tx_req, ap_ready, ap_done;
  logic [2:0]  phi_address;
  logic        phi_ce;
  logic [0:0]  y_address;
  logic        y_ce;
  logic [1:0]  x_address;
  logic        x_ce, x_we;
  logic [31:0] x_d;

  logic [7:0]  tx_byte;
  logic        tx_valid, ap_start, busy, overflow_err;
  logic [31:0] phi_q, y_q;
  logic [2:0]  state;

  logic [7:0]  seTxByte, zeTxByte;
  logic        seTxValid, zeTxValid, seApStart, zeApStart, seBusy, zeBusy, seOvf, zeOvf;
  logic [31:0] sePhiQ, zePhiQ, seYQ, zeYQ;
  logic [2:0]  seState, zeState;

  int errors = 0;
  int checks = 0;
  logic [7:0] seqTwo [8];

  typedef struct packed {
    logic        rdy;
    logic        done;
    logic        txreq;
    logic        xwr;
    logic [1:0]  xaddr;
    logic [31:0] xd;
    logic [2:0]  expState;
    logic        expStart;
    logic        expValid;
    logic [7:0]  expByte;
  } vec_t;

  vec_t vecs [19];

  cs_frame_controller #(.M(M), .N(N), .BPW(BPW), .SIGN_EXT(0)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_abort(frame_abort), .tx_req(tx_req), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .phi_address(phi_address), .phi_ce(phi_ce), .phi_q(phi_q),
    .y_address(y_address), .y_ce(y_ce), .y_q(y_q),
    .x_address(x_address), .x_ce(x_ce), .x_we(x_we), .x_d(x_d),
    .busy(busy), .state(state), .overflow_err(overflow_err)
  );

  cs_frame_controller #(.M(M), .N(N), .BPW(1), .SIGN_EXT(1)) dutSe (
    .clk(clk), .rst(rst), .rx_valid(rxValidSe), .rx_byte(rx_byte),
    .frame_abort(frame_abort), .tx_req(tx_req), .tx_byte(seTxByte), .tx_valid(seTxValid),
    .ap_start(seApStart), .ap_ready(ap_ready), .ap_done(ap_done),
    .phi_address(phi_address), .phi_ce(phi_ce), .phi_q(sePhiQ),
    .y_address(y_address), .y_ce(y_ce), .y_q(seYQ),
    .x_address(x_address), .x_ce(x_ce), .x_we(x_we), .x_d(x_d),
    .busy(seBusy), .state(seState), .overflow_err(seOvf)
  );

  cs_frame_controller #(.M(M), .N(N), .BPW(1), .SIGN_EXT(0)) dutZe (
    .clk(clk), .rst(rst), .rx_valid(rxValidSe), .rx_byte(rx_byte),
    .frame_abort(frame_abort), .tx_req(tx_req), .tx_byte(zeTxByte), .tx_valid(zeTxValid),
    .ap_start(zeApStart), .ap_ready(ap_ready), .ap_done(ap_done),
    .phi_address(phi_address), .phi_ce(phi_ce), .phi_q(zePhiQ),
    .y_address(y_address), .y_ce(y_ce), .y_q(zeYQ),
    .x_address(x_address), .x_ce(x_ce), .x_we(x_we), .x_d(x_d),
    .busy(zeBusy), .state(zeState), .overflow_err(zeOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearPulses();
    rx_valid    = 1'b0;
    rxValidSe   = 1'b0;
    frame_abort = 1'b0;
    tx_req      = 1'b0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    x_ce        = 1'b0;
    x_we        = 1'b0;
    y_ce        = 1'b0;
    phi_ce      = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ap_ready  = v.rdy;
    ap_done   = v.done;
    tx_req    = v.txreq;
    x_ce      = v.xwr;
    x_we      = v.xwr;
    x_address = v.xaddr;
    x_d       = v.xd;
    tick();
    clearPulses();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic readY(input logic [0:0] a);
    y_address = a;
    y_ce      = 1'b1;
    tick();
    y_ce      = 1'b0;
  endtask

  task automatic readPhi(input logic [2:0] a);
    phi_address = a;
    phi_ce      = 1'b1;
    tick();
    phi_ce      = 1'b0;
  endtask

  task automatic loadFrame(input logic [7:0] yBase, input logic [7:0] phiBase);
    for (int i = 0; i < M*BPW; i++) sendByte(yBase + 8'(i));
    for (int i = 0; i < M*N*BPW; i++) sendByte(phiBase + 8'(i));
  endtask

  function automatic vec_t mkVec(input logic rdy, input logic done, input logic txreq,
                                 input logic xwr, input logic [1:0] xaddr, input logic [31:0] xd,
                                 input logic [2:0] st, input logic start, input logic valid,
                                 input logic [7:0] byt);
    vec_t v;
    v.rdy = rdy; v.done = done; v.txreq = txreq; v.xwr = xwr; v.xaddr = xaddr; v.xd = xd;
    v.expState = st; v.expStart = start; v.expValid = valid; v.expByte = byt;
    return v;
  endfunction

  initial begin
    seqTwo = '{8'hCD, 8'hAB, 8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h43};

    for (int i = 0; i < 5; i++) vecs[i] = mkVec(0, 0, 0, 0, 2'd0, 32'h0, 3'd2, 1, 0, 8'h00);
    vecs[5] = mkVec(1, 0, 0, 0, 2'd0, 32'h0, 3'd3, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) vecs[6+i] = mkVec(0, 0, 0, 1, 2'(i), 32'h0000ABCD, 3'd3, 0, 0, 8'h00);
    vecs[10] = mkVec(0, 1, 0, 0, 2'd0, 32'h0, 3'd4, 0, 1, 8'hCD);
    for (int k = 1; k < 8; k++)
      vecs[10+k] = mkVec(0, 0, 1, 0, 2'd0, 32'h0, 3'd4, 0, 1, (k % 2 == 1) ? 8'hAB : 8'hCD);
    vecs[18] = mkVec(0, 0, 1, 0, 2'd0, 32'h0, 3'd0, 0, 0, 8'h00);

    rst = 1'b1;
    rx_byte = 8'h00; phi_address = '0; y_address = '0; x_address = '0; x_d = '0;
    clearPulses();
    repeat (2) tick();
    checkOutput("rst.state", 32'(state), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.ap_start", 32'(ap_start), 32'd0);
    checkOutput("rst.tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst.tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("rst.overflow", 32'(overflow_err), 32'd0);
    checkOutput("rst.y_q", y_q, 32'd0);
    checkOutput("rst.phi_q", phi_q, 32'd0);
    rst = 1'b0;
    tick();

    rx_byte = 8'h80;
    rxValidSe = 1'b1;
    tick();
    rxValidSe = 1'b0;
    readY(1'b0);
    checkOutput("signext.y_q", seYQ, 32'hFFFFFF80);
    checkOutput("zeroext.y_q", zeYQ, 32'h00000080);

    for (int i = 0; i < M*BPW; i++) sendByte(8'h01 + 8'(i));
    checkOutput("f1.state_after_y", 32'(state), 32'd1);
    for (int i = 0; i < M*N*BPW; i++) sendByte(8'h10 + 8'(i));
    checkOutput("f1.state_start", 32'(state), 32'd2);
    checkOutput("f1.ap_start", 32'(ap_start), 32'd1);
    checkOutput("f1.busy", 32'(busy), 32'd1);
    readY(1'b1);
    checkOutput("f1.y1", y_q, 32'h00000403);
    readY(1'b0);
    checkOutput("f1.y0", y_q, 32'h00000201);
    readPhi(3'd7);
    checkOutput("f1.phi7", phi_q, 32'h00001F1E);
    phi_address = 3'd0;
    tick();
    checkOutput("f1.phi_hold", phi_q, 32'h00001F1E);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].expState));
      checkOutput($sformatf("vec%0d.ap_start", i), 32'(ap_start), 32'(vecs[i].expStart));
      checkOutput($sformatf("vec%0d.tx_valid", i), 32'(tx_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.tx_byte", i), 32'(tx_byte), 32'(vecs[i].expByte));
    end

    x_ce = 1'b1; x_we = 1'b1; x_address = 2'd0; x_d = 32'h00007777;
    tick();
    clearPulses();

    for (int i = 0; i < M*BPW; i++) sendByte(8'h05 + 8'(i));
    for (int i = 0; i < 3; i++) sendByte(8'h20 + 8'(i));
    frame_abort = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
    tick();
    clearPulses();
    checkOutput("abort.state", 32'(state), 32'd0);
    checkOutput("abort.no_overflow", 32'(overflow_err), 32'd0);
    loadFrame(8'h05, 8'h20);
    checkOutput("f2.state_start", 32'(state), 32'd2);
    readY(1'b0);
    checkOutput("f2.y0", y_q, 32'h00000605);
    readPhi(3'd3);
    checkOutput("f2.phi3", phi_q, 32'h00002726);
    ap_ready = 1'b1;
    tick();
    clearPulses();
    checkOutput("f2.state_solve", 32'(state), 32'd3);
    for (int a = 1; a < 4; a++) begin
      x_ce = 1'b1; x_we = 1'b1; x_address = 2'(a);
      x_d = {16'hDEAD, 8'h40 + 8'(a), 8'h30 + 8'(a)};
      tick();
      clearPulses();
    end
    rx_valid = 1'b1; rx_byte = 8'h55;
    tick();
    clearPulses();
    checkOutput("f2.overflow_set", 32'(overflow_err), 32'd1);
    checkOutput("f2.state_still_solve", 32'(state), 32'd3);
    ap_done = 1'b1;
    tick();
    clearPulses();
    checkOutput("f2.state_send", 32'(state), 32'd4);
    checkOutput("f2.byte0", 32'(tx_byte), 32'(seqTwo[0]));
    checkOutput("f2.overflow_sticky", 32'(overflow_err), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tx_req = 1'b1;
      tick();
      clearPulses();
      checkOutput($sformatf("f2.byte%0d", k), 32'(tx_byte), 32'(seqTwo[k]));
    end

    rst = 1'b1;
    #1;
    checkOutput("midrst.tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("midrst.tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst.state", 32'(state), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.ap_start", 32'(ap_start), 32'd0);
    checkOutput("midrst.overflow", 32'(overflow_err), 32'd0);
    checkOutput("midrst.y_q", y_q, 32'd0);
    checkOutput("midrst.phi_q", phi_q, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    loadFrame(8'h01, 8'h10);
    checkOutput("f3.state_start", 32'(state), 32'd2);
    frame_abort = 1'b1; tx_req = 1'b1;
    tick();
    clearPulses();
    checkOutput("f3.abort_ignored", 32'(state), 32'd2);
    checkOutput("f3.tx_valid_idle", 32'(tx_valid), 32'd0);
    ap_ready = 1'b1; ap_done = 1'b1;
    tick();
    clearPulses();
    checkOutput("f3.direct_send", 32'(state), 32'd4);
    checkOutput("f3.byte0", 32'(tx_byte), 32'(seqTwo[0]));
    for (int k = 1; k <= 8; k++) begin
      tx_req = 1'b1;
      tick();
      clearPulses();
      if (k < 8) begin
        checkOutput($sformatf("f3.byte%0d", k), 32'(tx_byte), 32'(seqTwo[k]));
        checkOutput($sformatf("f3.valid%0d", k), 32'(tx_valid), 32'd1);
      end else begin
        checkOutput("f3.end_state", 32'(state), 32'd0);
        checkOutput("f3.end_valid", 32'(tx_valid), 32'd0);
        checkOutput("f3.end_byte", 32'(tx_byte), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
